// File: rtl/bydin_pkg.sv
// Shared definitions for the byte-deinterleaver read side.
// Read-controller state encoding and the default frame size (288 rows x 224 columns).
// Imported by the read controller and its byte FIFO.
package bydin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam logic [16:0] BYDIN_FRAME_LEN = 17'd64512;

endpackage

// File: rtl/bydin_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head byte visible on rd_data.
// Latency: a write is visible on rd_data the cycle after wr_en.
// Backpressure: writes while full and reads while empty are ignored.
module bydin_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_comb begin
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  // Storage is cleared on reset so the head byte reads 8'h00 when empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bydin_rd_ctrl.sv
// Issues one frame of memory read strobes per interrupt and buffers returned bytes for SPI tx.
// Latency: trigger to first read 1 cycle; returned byte to tx_valid 1 cycle when the FIFO is empty.
// Backpressure: reads are credit-limited to FIFO_DEPTH bytes buffered or in flight, so no byte is lost.
module bydin_rd_ctrl
  import bydin_pkg::*;
#(
  parameter logic [16:0] FRAME_LEN  = BYDIN_FRAME_LEN,
  parameter int          FIFO_DEPTH = 16,
  parameter int          RD_LAT     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bydin_int,
  output logic       mem_rd_ena,
  input  logic [7:0] mem_data_in,
  input  logic       mem_ena_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_busy,
  output logic       frame_done,
  output logic [1:0] err_status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // A memory latency above the credit still works, only the read rate drops.
  if (RD_LAT > FIFO_DEPTH) begin : g_credit_below_latency
  end

  rd_state_e     state_q, state_d;
  logic          int_q;
  logic          trig;
  logic [16:0]   req_cnt_q, req_cnt_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          mem_rd_ena_q, mem_rd_ena_d;
  logic          frame_busy_q, frame_busy_d;
  logic          frame_done_q, frame_done_d;
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] fifo_cnt, fifo_cnt_next;
  logic [CW:0]   credit_used;
  logic          fifo_full, fifo_empty;
  logic          fifo_wr, fifo_pop, ret_dec, in_frame;

  assign trig     = bydin_int & ~int_q;
  assign in_frame = (state_q == READ) || (state_q == DRAIN);
  assign fifo_wr  = mem_ena_in & in_frame & ~fifo_full;
  assign fifo_pop = tx_valid & tx_ready;
  // Every returned byte consumes a credit, even one that gets dropped.
  assign ret_dec  = mem_ena_in & (outstanding_q != '0);

  assign tx_valid   = ~fifo_empty;
  assign mem_rd_ena = mem_rd_ena_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign err_status = err_q;

  bydin_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (mem_data_in),
    .rd_en   (fifo_pop),
    .rd_data (tx_data),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame FSM, request/credit counters, sticky errors and next read strobe.
  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    fifo_cnt_next = fifo_cnt + CW'(fifo_wr) - CW'(fifo_pop);

    if (mem_rd_ena_q) begin
      req_cnt_d = req_cnt_q + 17'd1;
    end
    case ({mem_rd_ena_q, ret_dec})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if (mem_ena_in && !fifo_wr) begin
      err_d[0] = 1'b1;
    end
    if (trig && (state_q != IDLE)) begin
      err_d[1] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d       = READ;
          req_cnt_d     = '0;
          outstanding_d = '0;
        end
      end
      READ: begin
        if (mem_rd_ena_q && (req_cnt_q == FRAME_LEN - 17'd1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Next-cycle values so DONE lands the cycle right after the last pop.
        if ((outstanding_d == '0) && (fifo_cnt_next == '0)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    credit_used  = {1'b0, fifo_cnt_next} + {1'b0, outstanding_d};
    mem_rd_ena_d = (state_d == READ) && (req_cnt_d < FRAME_LEN) &&
                   (credit_used < (CW+1)'(FIFO_DEPTH));
    frame_busy_d = (state_d == READ) || (state_d == DRAIN);
    frame_done_d = (state_d == DONE);
  end

  // All control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      int_q         <= 1'b0;
      req_cnt_q     <= '0;
      outstanding_q <= '0;
      mem_rd_ena_q  <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      int_q         <= bydin_int;
      req_cnt_q     <= req_cnt_d;
      outstanding_q <= outstanding_d;
      mem_rd_ena_q  <= mem_rd_ena_d;
      frame_busy_q  <= frame_busy_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_bydin_rd_ctrl.sv
// Bench for bydin_rd_ctrl: two instances (40-byte and 1000-byte frames) behind a
// pipelined memory model; returned bytes are scoreboarded against a queue filled
// when each frame is triggered.
module tb_bydin_rd_ctrl;

  localparam int          RD_LAT = 4;
  localparam int          DEPTH  = 16;
  localparam logic [16:0] LEN_A  = 17'd40;
  localparam logic [16:0] LEN_L  = 17'd1000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] mem_byte(input int idx);
    logic [31:0] v;
    v = 32'(idx * 37 + (idx >>> 5) + 92);
    return v[7:0];
  endfunction

  // ---------------- instance A (40-byte frames) ----------------
  logic       int_a = 1'b0;
  logic       txr_a = 1'b1;
  logic       rd_a, mena_a, txv_a, busy_a, done_a;
  logic [7:0] mdat_a, txd_a;
  logic [1:0] err_a;

  bydin_rd_ctrl #(.FRAME_LEN(LEN_A), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .bydin_int(int_a), .mem_rd_ena(rd_a),
    .mem_data_in(mdat_a), .mem_ena_in(mena_a), .tx_data(txd_a), .tx_valid(txv_a),
    .tx_ready(txr_a), .frame_busy(busy_a), .frame_done(done_a), .err_status(err_a)
  );

  logic [RD_LAT-1:0] pv_a = '0;
  logic [7:0]        pd_a [RD_LAT];
  int                rdcnt_a = 0;
  logic              stray_v = 1'b0;
  logic [7:0]        stray_d = 8'h00;

  assign mena_a = pv_a[RD_LAT-1] | stray_v;
  assign mdat_a = stray_v ? stray_d : pd_a[RD_LAT-1];

  always @(negedge clk) begin
    pv_a    <= {pv_a[RD_LAT-2:0], rd_a};
    pd_a[0] <= mem_byte(rdcnt_a);
    for (int i = 1; i < RD_LAT; i++) pd_a[i] <= pd_a[i-1];
    if (rd_a) rdcnt_a <= rdcnt_a + 1;
  end

  logic [7:0] exp_a [$];
  logic [7:0] ea;
  int rdp_a = 0, pops_a = 0, dones_a = 0;

  always @(negedge clk) begin
    if (rd_a === 1'b1) rdp_a++;
    if (done_a === 1'b1) dones_a++;
    if (txv_a === 1'b1 && txr_a === 1'b1) begin
      pops_a++;
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL tx_byte_a: got %02h, expected no byte", txd_a);
      end else begin
        ea = exp_a.pop_front();
        if (txd_a !== ea) begin
          errors++;
          $display("FAIL tx_byte_a: got %02h, expected %02h", txd_a, ea);
        end
      end
    end
  end

  // ---------------- instance L (1000-byte frames) ----------------
  logic       int_l = 1'b0;
  logic       txr_l = 1'b1;
  logic       rd_l, mena_l, txv_l, busy_l, done_l;
  logic [7:0] mdat_l, txd_l;
  logic [1:0] err_l;

  bydin_rd_ctrl #(.FRAME_LEN(LEN_L), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_dut_l (
    .clk(clk), .reset_n(reset_n), .bydin_int(int_l), .mem_rd_ena(rd_l),
    .mem_data_in(mdat_l), .mem_ena_in(mena_l), .tx_data(txd_l), .tx_valid(txv_l),
    .tx_ready(txr_l), .frame_busy(busy_l), .frame_done(done_l), .err_status(err_l)
  );

  logic [RD_LAT-1:0] pv_l = '0;
  logic [7:0]        pd_l [RD_LAT];
  int                rdcnt_l = 0;

  assign mena_l = pv_l[RD_LAT-1];
  assign mdat_l = pd_l[RD_LAT-1];

  always @(negedge clk) begin
    pv_l    <= {pv_l[RD_LAT-2:0], rd_l};
    pd_l[0] <= mem_byte(rdcnt_l);
    for (int i = 1; i < RD_LAT; i++) pd_l[i] <= pd_l[i-1];
    if (rd_l) rdcnt_l <= rdcnt_l + 1;
  end

  logic [7:0] exp_l [$];
  logic [7:0] el;
  int rdp_l = 0, pops_l = 0, dones_l = 0, inflight_max = 0;

  always @(negedge clk) begin
    if (rd_l === 1'b1) rdp_l++;
    if (rdp_l - pops_l > inflight_max) inflight_max = rdp_l - pops_l;
    if (done_l === 1'b1) dones_l++;
    if (txv_l === 1'b1 && txr_l === 1'b1) begin
      pops_l++;
      checks++;
      if (exp_l.size() == 0) begin
        errors++;
        $display("FAIL tx_byte_l: got %02h, expected no byte", txd_l);
      end else begin
        el = exp_l.pop_front();
        if (txd_l !== el) begin
          errors++;
          $display("FAIL tx_byte_l: got %02h, expected %02h", txd_l, el);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic push_frame_a();
    for (int k = 0; k < int'(LEN_A); k++) exp_a.push_back(mem_byte(rdcnt_a + k));
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: frame_done not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_frame_a(input string tag, input int r0, input int p0, input int d0,
                               input logic [1:0] err_exp);
    checks++;
    if (rdp_a - r0 != int'(LEN_A)) begin
      errors++;
      $display("FAIL %s_reads: got %0d, expected %0d", tag, rdp_a - r0, LEN_A);
    end
    checks++;
    if (pops_a - p0 != int'(LEN_A)) begin
      errors++;
      $display("FAIL %s_pops: got %0d, expected %0d", tag, pops_a - p0, LEN_A);
    end
    checks++;
    if (dones_a - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, expected 1", tag, dones_a - d0);
    end
    checks++;
    if (err_a !== err_exp) begin
      errors++;
      $display("FAIL %s_err: got %b, expected %b", tag, err_a, err_exp);
    end
    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d bytes missing, expected 0", tag, exp_a.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (rd_a !== 1'b0 || txv_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got rd=%b txv=%b busy=%b done=%b, expected all 0",
               tag, rd_a, txv_a, busy_a, done_a);
    end
    checks++;
    if (txd_a !== 8'h00) begin
      errors++;
      $display("FAIL %s_tx_data: got %02h, expected 00", tag, txd_a);
    end
    checks++;
    if (err_a !== 2'b00) begin
      errors++;
      $display("FAIL %s_err: got %b, expected 00", tag, err_a);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    checks++;
    if (rd_l !== 1'b0 || txv_l !== 1'b0 || busy_l !== 1'b0 || err_l !== 2'b00) begin
      errors++;
      $display("FAIL reset_l: got rd=%b txv=%b busy=%b err=%b, expected 0/0/0/00",
               rd_l, txv_l, busy_l, err_l);
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    int run, r0, p0, d0;
    @(posedge clk); #1;
    r0 = rdp_a; p0 = pops_a; d0 = dones_a;
    push_frame_a();
    int_a = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd_early: got %b in trigger cycle, expected 0", rd_a);
    end
    @(negedge clk);
    checks++;
    if (rd_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_rd: got rd=%b busy=%b, expected 1/1", rd_a, busy_a);
    end
    run = 0;
    for (int i = 0; i < 200 && rd_a === 1'b1; i++) begin
      run++;
      if (i == 14) int_a = 1'b0;
      @(negedge clk);
    end
    int_a = 1'b0;
    checks++;
    if (run != int'(LEN_A)) begin
      errors++;
      $display("FAIL basic_rd_run: got %0d contiguous reads, expected %0d", run, LEN_A);
    end
    wait_done_a("basic", 400);
    @(negedge clk);
    check_frame_a("basic", r0, p0, d0, 2'b00);
  endtask

  task automatic test_backpressure();
    int r0, p0, d0;
    @(posedge clk); #1;
    r0 = rdp_a; p0 = pops_a; d0 = dones_a;
    txr_a = 1'b0;
    push_frame_a();
    int_a = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 16) int_a = 1'b0;
    end
    checks++;
    if (rdp_a - r0 != DEPTH) begin
      errors++;
      $display("FAIL bp_reads_stalled: got %0d reads, expected %0d", rdp_a - r0, DEPTH);
    end
    checks++;
    if (txv_a !== 1'b1 || rd_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_state: got txv=%b rd=%b, expected 1/0", txv_a, rd_a);
    end
    @(posedge clk); #1 txr_a = 1'b1;
    @(negedge clk);
    wait_done_a("bp", 400);
    @(negedge clk);
    check_frame_a("bp", r0, p0, d0, 2'b00);
  endtask

  task automatic test_random_ready();
    int p0, d0, n;
    @(posedge clk); #1;
    p0 = pops_l; d0 = dones_l; inflight_max = 0;
    for (int k = 0; k < int'(LEN_L); k++) exp_l.push_back(mem_byte(rdcnt_l + k));
    int_l = 1'b1;
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      if (done_l === 1'b1) break;
      @(posedge clk); #1;
      txr_l = ($urandom_range(0, 99) < 30);
      if (n == 16) int_l = 1'b0;
      n++;
    end
    int_l = 1'b0;
    checks++;
    if (done_l !== 1'b1) begin
      errors++;
      $display("FAIL rand_timeout: frame_done not seen within %0d cycles", n);
    end
    @(posedge clk); #1 txr_l = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (pops_l - p0 != int'(LEN_L)) begin
      errors++;
      $display("FAIL rand_pops: got %0d, expected %0d", pops_l - p0, LEN_L);
    end
    checks++;
    if (dones_l - d0 != 1) begin
      errors++;
      $display("FAIL rand_done_count: got %0d, expected 1", dones_l - d0);
    end
    checks++;
    if (inflight_max > DEPTH) begin
      errors++;
      $display("FAIL rand_credit: got max %0d in flight+buffered, expected <= %0d", inflight_max, DEPTH);
    end
    checks++;
    if (err_l !== 2'b00 || exp_l.size() != 0) begin
      errors++;
      $display("FAIL rand_end: got err=%b leftover=%0d, expected 00/0", err_l, exp_l.size());
    end
  endtask

  task automatic test_trigger_busy();
    int r0, p0, d0;
    @(posedge clk); #1;
    r0 = rdp_a; p0 = pops_a; d0 = dones_a;
    push_frame_a();
    int_a = 1'b1;
    repeat (10) @(posedge clk);
    #1 int_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 int_a = 1'b1;
    repeat (5) @(posedge clk);
    #1 int_a = 1'b0;
    @(negedge clk);
    checks++;
    if (err_a !== 2'b10 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_trig_err: got err=%b busy=%b, expected 10/1", err_a, busy_a);
    end
    wait_done_a("busy_trig", 400);
    @(negedge clk);
    check_frame_a("busy_trig", r0, p0, d0, 2'b10);
    repeat (30) @(negedge clk);
    checks++;
    if (rdp_a - r0 != int'(LEN_A) || busy_a !== 1'b0 || dones_a - d0 != 1) begin
      errors++;
      $display("FAIL busy_trig_no_second: got reads=%0d busy=%b dones=%0d, expected %0d/0/1",
               rdp_a - r0, busy_a, dones_a - d0, LEN_A);
    end
  endtask

  task automatic test_stray_return();
    do_reset();
    @(posedge clk); #1;
    stray_d = 8'hA5;
    stray_v = 1'b1;
    @(posedge clk); #1 stray_v = 1'b0;
    @(negedge clk);
    checks++;
    if (err_a !== 2'b01) begin
      errors++;
      $display("FAIL stray_err: got %b, expected 01", err_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (txv_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL stray_txv: got txv=%b busy=%b, expected 0/0", txv_a, busy_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0, r1, n;
    do_reset();
    @(posedge clk); #1;
    p0 = pops_a;
    push_frame_a();
    int_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 int_a = 1'b0;
    n = 0;
    while (pops_a - p0 < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pops_a - p0 < 10) begin
      errors++;
      $display("FAIL midrst_timeout: got %0d bytes, expected 10", pops_a - p0);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    txr_a   = 1'b0;
    exp_a.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    txr_a   = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    r1 = rdp_a;
    repeat (12) @(negedge clk);
    checks++;
    if (err_a !== 2'b01) begin
      errors++;
      $display("FAIL midrst_inflight_err: got %b, expected 01", err_a);
    end
    checks++;
    if (rdp_a != r1 || txv_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: got reads=%0d txv=%b busy=%b, expected 0/0/0",
               rdp_a - r1, txv_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random_ready();
    test_trigger_busy();
    test_stray_return();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
